// File: rtl/temp_poll_scheduler_if.sv
// Handshake between the temperature poll scheduler and the I2C read controller.
// The scheduler is the master: it raises Go and consumes Done and the received bytes.
interface temp_poll_scheduler_if;
    logic       Go;
    logic       Done;
    logic       RxValid;
    logic [7:0] RxByte;

    modport master (
        output Go,
        input  Done,
        input  RxValid,
        input  RxByte
    );

    modport slave (
        input  Go,
        output Done,
        output RxValid,
        output RxByte
    );
endinterface

// File: rtl/temp_poll_scheduler.sv
// Schedules periodic and on-demand reads of a 16-bit I2C temperature sensor,
// assembles the two received bytes and publishes Temp with alarm and error flags.
module temp_poll_scheduler #(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 200
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  ReadNow,
    input  logic [15:0]           Threshold,
    temp_poll_scheduler_if.master i2c,
    output logic [15:0]           Temp,
    output logic                  TempValid,
    output logic                  Alarm,
    output logic                  Error
);

    localparam int PERIOD_W  = (PERIOD > 1)  ? $clog2(PERIOD)  : 1;
    localparam int TIMEOUT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        UPDATE,
        FAULT
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  pending;
    logic [PERIOD_W-1:0]   periodCnt;
    logic [TIMEOUT_W-1:0]  timeoutCnt;
    logic [1:0]            byteCnt;
    logic [15:0]           shadow;

    logic periodTick;
    logic request;
    logic consume;
    logic timedOut;
    logic fullWord;

    assign periodTick = Enable && (periodCnt == PERIOD_W'(PERIOD - 1));
    assign request    = ReadNow || periodTick;
    assign consume    = (state == IDLE) && pending;
    assign timedOut   = (timeoutCnt == TIMEOUT_W'(TIMEOUT - 1));
    assign fullWord   = (byteCnt == 2'd2);

    // NOTE: Reset is synchronous, so it is tested inside the clocked block and
    // is absent from the sensitivity list.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment keeps every register sampling the
            // pre-edge values, independent of block ordering.
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        stateNext = state;
        i2c.Go    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) stateNext = ISSUE;
            end
            ISSUE: begin
                i2c.Go    = 1'b1;
                stateNext = BUSY;
            end
            BUSY: begin
                i2c.Go = 1'b1;
                // Done outranks the timeout when both land on the same cycle.
                if (i2c.Done)    stateNext = fullWord ? UPDATE : FAULT;
                else if (timedOut) stateNext = FAULT;
            end
            UPDATE:  stateNext = IDLE;
            FAULT:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A request in the same cycle IDLE consumes pending must survive, so set wins.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            pending <= 1'b0;
        end else if (request) begin
            pending <= 1'b1;
        end else if (consume) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset || !Enable) begin
            periodCnt <= '0;
        end else if (periodTick) begin
            periodCnt <= '0;
        end else begin
            periodCnt <= periodCnt + PERIOD_W'(1);
        end
    end

    // Byte assembly and timeout tracking for the transaction in flight.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            byteCnt    <= 2'd0;
            timeoutCnt <= '0;
            // NOTE: shadow is an ordinary register, not a memory, so it is
            // reset with the rest of the state.
            shadow     <= 16'h0000;
        end else begin
            case (state)
                ISSUE: begin
                    byteCnt    <= 2'd0;
                    timeoutCnt <= '0;
                end
                BUSY: begin
                    timeoutCnt <= timeoutCnt + TIMEOUT_W'(1);
                    if (i2c.RxValid) begin
                        if (byteCnt == 2'd0) shadow[15:8] <= i2c.RxByte;
                        if (byteCnt == 2'd1) shadow[7:0]  <= i2c.RxByte;
                        if (!fullWord)       byteCnt      <= byteCnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TempValid is registered so its pulse lines up with the new Temp value.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            Temp      <= 16'h0000;
            TempValid <= 1'b0;
            Alarm     <= 1'b0;
            Error     <= 1'b0;
        end else begin
            TempValid <= 1'b0;
            case (state)
                UPDATE: begin
                    Temp      <= shadow;
                    TempValid <= 1'b1;
                    Error     <= 1'b0;
                    Alarm     <= ($signed(shadow) >= $signed(Threshold));
                end
                FAULT: begin
                    Error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Randomised self-checking bench for temp_poll_scheduler; a transaction-level model
// predicts Temp, Alarm and Error from the bytes, Done timing and Threshold.
module tb_temp_poll_scheduler;
    localparam int PERIOD  = 8;
    localparam int TIMEOUT = 20;

    logic        clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        ReadNow;
    logic [15:0] Threshold;
    logic [15:0] Temp;
    logic        TempValid;
    logic        Alarm;
    logic        Error;

    temp_poll_scheduler_if bus ();

    temp_poll_scheduler #(
        .PERIOD (PERIOD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .ReadNow  (ReadNow),
        .Threshold(Threshold),
        .i2c      (bus.master),
        .Temp     (Temp),
        .TempValid(TempValid),
        .Alarm    (Alarm),
        .Error    (Error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks = 0;
    int passes = 0;

    // Reference model of the published results.
    logic [15:0] mTemp  = 16'h0000;
    logic        mAlarm = 1'b0;
    logic        mError = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReadNow();
        ReadNow = 1'b1;
        tick();
        ReadNow = 1'b0;
    endtask

    task automatic waitGo(input int bound, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < bound) begin
            tick();
            n++;
            seen = (bus.Go === 1'b1);
        end
    endtask

    // Plays the I2C controller for one transaction that has already been requested.
    task automatic runRead(input string tag, input int nBytes, input logic [7:0] hi,
                           input logic [7:0] lo, input bit answer, input int maxGap,
                           input int extraReqs, input int doneDelay, output int goAt);
        bit   seen;
        int   n;
        int   goCycles;
        logic tvEarly;
        bit   good;
        goAt = -1;
        waitGo(PERIOD + 6, seen, n);
        checks++;
        if (!seen) begin
            $display("FAIL %s go_start: Go=%b after %0d cycles, required 1", tag, bus.Go, n);
            return;
        end
        passes++;
        goAt = cyc;
        if (!answer) begin
            goCycles = 0;
            tvEarly  = 1'b0;
            while (bus.Go === 1'b1 && goCycles < 3 * TIMEOUT) begin
                goCycles++;
                tvEarly |= TempValid;
                tick();
            end
            checks++;
            if (goCycles !== TIMEOUT + 1)
                $display("FAIL %s go_width: Go high %0d cycles, required %0d", tag, goCycles, TIMEOUT + 1);
            else passes++;
            tvEarly |= TempValid;
            tick();
            checks++;
            if ({tvEarly, TempValid} !== 2'b00)
                $display("FAIL %s no_tempvalid: TempValid seen %b/%b, required 0/0", tag, tvEarly, TempValid);
            else passes++;
            mError = 1'b1;
        end else begin
            tick();
            checks++;
            if (bus.Go !== 1'b1) $display("FAIL %s busy_go: Go=%b, required 1", tag, bus.Go);
            else passes++;
            for (int k = 0; k < extraReqs; k++) begin
                ReadNow = 1'b1;
                tick();
                ReadNow = 1'b0;
                tick();
            end
            for (int i = 0; i < nBytes; i++) begin
                bus.RxByte  = (i == 0) ? hi : ((i == 1) ? lo : 8'($urandom));
                bus.RxValid = 1'b1;
                tick();
                bus.RxValid = 1'b0;
                bus.RxByte  = 8'($urandom);
                repeat ($urandom_range(0, maxGap)) tick();
            end
            repeat (doneDelay) tick();
            bus.Done = 1'b1;
            tick();
            bus.Done = 1'b0;
            tvEarly = TempValid;
            checks++;
            if (bus.Go !== 1'b0) $display("FAIL %s go_low_1: Go=%b, required 0", tag, bus.Go);
            else passes++;
            tick();
            checks++;
            if (bus.Go !== 1'b0) $display("FAIL %s go_low_2: Go=%b, required 0", tag, bus.Go);
            else passes++;
            good = (nBytes >= 2);
            if (good) begin
                mTemp  = {hi, lo};
                mAlarm = ($signed({hi, lo}) >= $signed(Threshold));
                mError = 1'b0;
            end else begin
                mError = 1'b1;
            end
            checks++;
            if ({tvEarly, TempValid} !== {1'b0, good})
                $display("FAIL %s tempvalid: seen %b then %b, required 0 then %b", tag, tvEarly, TempValid, good);
            else passes++;
        end
        checks++;
        if ({Temp, Alarm, Error} !== {mTemp, mAlarm, mError})
            $display("FAIL %s result: Temp=%h Alarm=%b Error=%b, required Temp=%h Alarm=%b Error=%b",
                     tag, Temp, Alarm, Error, mTemp, mAlarm, mError);
        else passes++;
    endtask

    task automatic test_reset();
        int goHigh;
        Reset = 1'b0; Enable = 1'b1; ReadNow = 1'b1; Threshold = 16'h8000;
        bus.Done = 1'b1; bus.RxValid = 1'b1; bus.RxByte = 8'hFF;
        repeat (3) tick();
        checks++;
        if ({bus.Go, TempValid, Alarm, Error} !== 4'b0000)
            $display("FAIL reset_flags: Go/TempValid/Alarm/Error=%b, required 0000", {bus.Go, TempValid, Alarm, Error});
        else passes++;
        checks++;
        if (Temp !== 16'h0000) $display("FAIL reset_temp: Temp=%h, required 0000", Temp);
        else passes++;
        Enable = 1'b0; ReadNow = 1'b0; bus.Done = 1'b0; bus.RxValid = 1'b0; Reset = 1'b1;
        goHigh = 0;
        repeat (2 * PERIOD) begin tick(); goHigh += int'(bus.Go); end
        checks++;
        if (goHigh !== 0) $display("FAIL reset_quiet: Go high %0d cycles, required 0", goHigh);
        else passes++;
    endtask

    task automatic test_read_alarm();
        int goAt;
        Threshold = 16'h1900;
        pulseReadNow();
        runRead("read_alarm", 2, 8'h19, 8'h80, 1'b1, 0, 0, 0, goAt);
        checks++;
        if ({Temp, Alarm, Error} !== {16'h1980, 1'b1, 1'b0})
            $display("FAIL read_alarm_value: Temp=%h Alarm=%b Error=%b, required 1980 1 0", Temp, Alarm, Error);
        else passes++;
        tick();
        checks++;
        if (TempValid !== 1'b0) $display("FAIL read_alarm_pulse_end: TempValid=%b, required 0", TempValid);
        else passes++;
        pulseReadNow();
        runRead("extra_byte", 3, 8'h05, 8'h3C, 1'b1, 1, 0, 0, goAt);
    endtask

    task automatic test_timeout();
        int goAt;
        pulseReadNow();
        runRead("timeout", 0, 8'h00, 8'h00, 1'b0, 0, 0, 0, goAt);
        pulseReadNow();
        runRead("done_at_limit", 2, 8'h21, 8'h07, 1'b1, 0, 0, TIMEOUT - 3, goAt);
    endtask

    task automatic test_short_read();
        int goAt;
        pulseReadNow();
        runRead("short", 1, 8'h12, 8'h00, 1'b1, 0, 0, 0, goAt);
        pulseReadNow();
        runRead("short_recover", 2, 8'($urandom), 8'($urandom), 1'b1, 0, 0, 0, goAt);
    endtask

    task automatic test_periodic();
        int goAt;
        int prevAt;
        int goHigh;
        Threshold = 16'($urandom);
        Enable = 1'b1;
        prevAt = -1;
        for (int i = 0; i < 5; i++) begin
            runRead($sformatf("periodic%0d", i), 2, 8'($urandom), 8'($urandom), 1'b1, 0, 0, 0, goAt);
            if (i > 0 && prevAt >= 0 && goAt >= 0) begin
                checks++;
                if (goAt - prevAt !== PERIOD)
                    $display("FAIL periodic_spacing%0d: Go rose %0d cycles apart, required %0d", i, goAt - prevAt, PERIOD);
                else passes++;
            end
            prevAt = goAt;
        end
        Enable = 1'b0;
        goHigh = 0;
        repeat (3 * PERIOD) begin tick(); goHigh += int'(bus.Go); end
        checks++;
        if (goHigh !== 0) $display("FAIL periodic_stop: Go high %0d cycles, required 0", goHigh);
        else passes++;
    endtask

    task automatic test_coalesce();
        int goAt;
        int goHigh;
        pulseReadNow();
        runRead("coalesce_first", 2, 8'($urandom), 8'($urandom), 1'b1, 0, 3, 0, goAt);
        runRead("coalesce_extra", 2, 8'($urandom), 8'($urandom), 1'b1, 0, 0, 0, goAt);
        goHigh = 0;
        repeat (30) begin tick(); goHigh += int'(bus.Go); end
        checks++;
        if (goHigh !== 0) $display("FAIL coalesce_single: Go high %0d cycles, required 0", goHigh);
        else passes++;
    endtask

    task automatic test_reset_mid_busy();
        int  goAt;
        int  n;
        int  goHigh;
        bit  seen;
        Threshold = 16'h0000;
        pulseReadNow();
        runRead("pre_reset", 2, 8'h25, 8'hA5, 1'b1, 0, 0, 0, goAt);
        pulseReadNow();
        waitGo(PERIOD, seen, n);
        tick();
        ReadNow = 1'b1; bus.RxValid = 1'b1; bus.RxByte = 8'h77;
        tick();
        ReadNow = 1'b0; bus.RxValid = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        mTemp = 16'h0000; mAlarm = 1'b0; mError = 1'b0;
        checks++;
        if ({bus.Go, TempValid, Alarm, Error, Temp} !== 20'h0_0000)
            $display("FAIL mid_busy_reset: Go=%b TempValid=%b Alarm=%b Error=%b Temp=%h, required all 0",
                     bus.Go, TempValid, Alarm, Error, Temp);
        else passes++;
        goHigh = 0;
        repeat (3 * TIMEOUT) begin tick(); goHigh += int'(bus.Go); end
        checks++;
        if (goHigh !== 0) $display("FAIL reset_no_resume: Go high %0d cycles, required 0", goHigh);
        else passes++;
        pulseReadNow();
        runRead("post_reset", 2, 8'($urandom), 8'($urandom), 1'b1, 0, 0, 0, goAt);
    endtask

    task automatic test_signed_compare();
        int goAt;
        Threshold = 16'hFF00;
        pulseReadNow();
        runRead("signed_eq", 2, 8'hFF, 8'h00, 1'b1, 0, 0, 0, goAt);
        checks++;
        if (Alarm !== 1'b1) $display("FAIL signed_eq_alarm: Alarm=%b, required 1", Alarm);
        else passes++;
        pulseReadNow();
        runRead("signed_below", 2, 8'hFE, 8'hFF, 1'b1, 0, 0, 0, goAt);
        checks++;
        if (Alarm !== 1'b0) $display("FAIL signed_below_alarm: Alarm=%b, required 0", Alarm);
        else passes++;
    endtask

    task automatic test_random();
        int goAt;
        for (int i = 0; i < 12; i++) begin
            Threshold = 16'($urandom);
            pulseReadNow();
            runRead($sformatf("rand%0d", i), $urandom_range(0, 3), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), 1, 0, $urandom_range(0, 4), goAt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; Enable = 1'b0; ReadNow = 1'b0; Threshold = 16'h0000;
        bus.Done = 1'b0; bus.RxValid = 1'b0; bus.RxByte = 8'h00;
        test_reset();
        test_read_alarm();
        test_timeout();
        test_short_read();
        test_periodic();
        test_coalesce();
        test_reset_mid_busy();
        test_signed_compare();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/temp_poll_scheduler.md
TEMP_POLL_SCHEDULER -- requirements
Module: temp_poll_scheduler

Interface
REQ-001 The block SHALL have parameter PERIOD, default 1000: clock cycles between automatic temperature reads.
REQ-002 The block SHALL have parameter TIMEOUT, default 200: maximum clock cycles allowed in BUSY before Done.
REQ-003 clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Reset  in  1  reset; synchronous, active-low.
REQ-005 Enable  in  1  1 = periodic polling runs.
REQ-006 ReadNow  in  1  one-cycle request for an immediate read.
REQ-007 Done  in  1  I2C read controller finished the transaction.
REQ-008 RxValid  in  1  one-cycle strobe; RxByte holds a received byte.
REQ-009 RxByte  in  8  received byte from the I2C datapath, MSB byte first.
REQ-010 Threshold  in  16  signed two's-complement alarm threshold.
REQ-011 Go  out  1  start/hold request to the I2C read controller.
REQ-012 Temp  out  16  last successfully read temperature.
REQ-013 TempValid  out  1  one-cycle pulse when Temp updates.
REQ-014 Alarm  out  1  1 = last Temp >= Threshold, signed compare.
REQ-015 Error  out  1  1 = last transaction timed out or was short.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, BUSY, UPDATE, FAULT.
REQ-017 IDLE: if pending=1, go to ISSUE next cycle and clear pending; else stay.
REQ-018 ISSUE: Go=1 for one cycle; clear byte counter and timeout counter; go to BUSY.
REQ-019 BUSY: Go SHALL remain 1 and the timeout counter SHALL increment every cycle.
REQ-020 BUSY with Done=1 and byte counter=2: go to UPDATE; with Done=1 and byte counter<2: go to FAULT.
REQ-021 BUSY with Done=0 and timeout counter=TIMEOUT-1: go to FAULT; Done takes priority when both occur in the same cycle.
REQ-022 In BUSY, RxValid with byte counter 0 SHALL load shadow[15:8]; with counter 1 it SHALL load shadow[7:0]; the counter SHALL saturate at 2; further bytes SHALL be ignored.
REQ-023 UPDATE, one cycle: Temp<=shadow; TempValid=1; Error<=0; Alarm<=($signed(shadow) >= $signed(Threshold)); then go to IDLE.
REQ-024 FAULT, one cycle: Error<=1; Temp, Alarm and TempValid SHALL be unchanged or 0 respectively; then go to IDLE.
REQ-025 Go SHALL be 0 in IDLE, UPDATE and FAULT, so Go is low for at least two cycles between transactions.
REQ-026 Period counter: while Enable=1, it SHALL count 0..PERIOD-1 and wrap; reaching PERIOD-1 SHALL set pending; Enable=0 SHALL clear it to 0.
REQ-027 ReadNow=1 SHALL set pending in any state.
REQ-028 Multiple requests while pending=1 or while not in IDLE SHALL coalesce into exactly one follow-up read.
REQ-029 A request arriving in the same cycle IDLE consumes pending SHALL leave pending=1.
REQ-030 Alarm and Error SHALL hold their values between updates.

Reset
REQ-031 On a rising clock edge with Reset=0, the block SHALL set: state=IDLE, Go=0, Temp=0, TempValid=0, Alarm=0, Error=0, pending=0, all counters=0, shadow=0.
REQ-032 Reset SHALL take priority over every input, including mid-BUSY; the block SHALL not resume the aborted transaction.

Verification (PERIOD=8, TIMEOUT=20)
REQ-033 Read with alarm: Enable=0, Threshold=0x1900, ReadNow pulse, then RxByte 0x19 and 0x80 with RxValid, then Done -> Temp=0x1980, one-cycle TempValid, Alarm=1, Error=0, Go low two cycles after Done.
REQ-034 Timeout: ReadNow, Done held 0 -> Go high for exactly 21 cycles (ISSUE plus 20 BUSY), then Error=1, Temp unchanged, no TempValid.
REQ-035 Short read: one RxValid byte 0x12, then Done -> FAULT, Error=1, TempValid never asserted; a following good read clears Error.
REQ-036 Periodic polling: Enable=1, each read answered within 3 cycles -> Go rises once per 8-cycle period, with no missed or extra reads.
REQ-037 Coalescing and reset: ReadNow pulsed 3 times during BUSY -> exactly one extra read. Reset=0 for one cycle mid-BUSY -> next edge Go=0, Temp=0, pending=0, state IDLE.
REQ-038 Signed compare: Threshold=0xFF00, Temp read 0xFF00 -> Alarm=1. Temp read 0xFEFF -> Alarm=0.
